gate_sweep_checker: RTL and testbench
=====================================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the wait cycles between driving a/b and sampling the DUT; the legal range SHALL be 1..15.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-004 start  input  1  request a full sweep; it SHALL be sampled only in IDLE.
REQ-005 a  output  1  registered stimulus to the gate DUT.
REQ-006 b  output  1  registered stimulus to the gate DUT.
REQ-007 and_in  input  1  DUT AND result.
REQ-008 or_in  input  1  DUT OR result.
REQ-009 not_in  input  1  DUT NOT(a) result.
REQ-010 busy  output  1  high from start acceptance until the cycle before done.
REQ-011 done  output  1  one-cycle pulse at sweep end.
REQ-012 pass  output  1  sweep result, held until the next accepted start.
REQ-013 err_count  output  4  number of failed checks in the last sweep (0..10).
REQ-014 fail_vec  output  10  bit k SHALL be 1 when check k failed.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and DONE, with a 4-bit check index idx running 0..9.
REQ-016 Check table (idx: gate, a, b, expected):
- 0-3: AND with ab=00,01,10,11; expected 0,0,0,1.
- 4-7: OR with ab=00,01,10,11; expected 0,1,1,1.
- 8-9: NOT with ab=00,10; expected 1,0.
REQ-017 When start=1 in IDLE, the block SHALL do all of the following on the same edge:
- set idx=0;
- clear err_count, fail_vec and pass;
- set busy=1;
- go to DRIVE.
REQ-018 In DRIVE (1 cycle), the block SHALL register a/b from the table for idx and go to SETTLE.
REQ-019 In SETTLE, the block SHALL stay exactly SETTLE_CYCLES cycles, holding a/b stable, and then go to SAMPLE.
REQ-020 In SAMPLE (1 cycle), the block SHALL do all of the following:
- compare the selected input (and_in / or_in / not_in by idx) with the expected value;
- on a mismatch, set fail_vec[idx] and increment err_count;
- go to DONE if idx==9, else increment idx and go to DRIVE.
REQ-021 Each check SHALL take SETTLE_CYCLES+2 cycles.
REQ-022 done SHALL assert 10*(SETTLE_CYCLES+2)+1 cycles after the start edge, which is 41 cycles at the default.
REQ-023 In DONE (1 cycle), the block SHALL do all of the following:
- assert done=1 and busy=0;
- set pass=1 if and only if err_count==0, counting the SAMPLE-9 update;
- go to IDLE.
REQ-024 While idle, a and b SHALL both return to 0 on the IDLE entry edge and stay 0.
REQ-025 start SHALL be ignored in DRIVE, SETTLE, SAMPLE and DONE; no queueing and no restart.
REQ-026 err_count SHALL never exceed 10 and SHALL need no saturation logic.
REQ-027 fail_vec, err_count and pass SHALL hold their values in IDLE until the next accepted start.
REQ-028 Dependence on DUT inputs:
- DUT inputs SHALL be sampled only in SAMPLE.
- X or changes on DUT inputs in any other state SHALL have no effect.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force all of the following, regardless of state:
- state=IDLE, idx=0;
- a=0, b=0;
- busy=0, done=0, pass=0;
- err_count=0, fail_vec=0.
REQ-030 Reset assertion mid-sweep SHALL abort the sweep with no done pulse.
REQ-031 After rst_n rises, the block SHALL accept a start on the first clock edge.

Verification
REQ-032 Ideal DUT model (and/or/not) with default parameter, start pulse -> done at cycle 41, pass=1, err_count=0, fail_vec=0; the a/b sequence SHALL match REQ-016 at every SAMPLE.
REQ-033 and_in stuck at 0 -> fail_vec=10'b0000001000, err_count=1, pass=0.
REQ-034 not_in stuck at 0 -> fail_vec=10'b0100000000, err_count=1, pass=0.
REQ-035 or_in stuck at 1 -> fail_vec=10'b0000010000, err_count=1, pass=0.
REQ-036 start re-pulsed at cycles 5 and 30 of a sweep -> ignored, exactly one done at cycle 41.
REQ-037 rst_n low during check idx=5 -> all outputs 0 immediately, no done; the next start runs a full sweep with pass=1 on the ideal DUT.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Drives an external AND/OR/NOT gate under test through a fixed 10-entry
//   check table. For each entry it registers a/b, waits SETTLE_CYCLES
//   cycles, then compares the matching gate output with the expected value.
//   Failures are recorded per check in fail_vec and counted in err_count.
//   pass is set at the end of the sweep when no check failed.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request a sweep (honoured only while idle)
//   a, b       out  registered stimulus to the gate under test
//   and_in     in   gate-under-test AND(a,b)
//   or_in      in   gate-under-test OR(a,b)
//   not_in     in   gate-under-test NOT(a)
//   busy       out  high from start acceptance until the cycle before done
//   done       out  one-cycle pulse at the end of a sweep
//   pass       out  sweep result, held until the next accepted start
//   err_count  out  number of failed checks in the last sweep (0..10)
//   fail_vec   out  bit k set when check k failed
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [9:0] fail_vec
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX    = 4'd9;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [9:0] fv_q, fv_d;

  // Check table: 0-3 AND, 4-7 OR (ab = idx[1:0]), 8-9 NOT with ab = 00, 10.
  function automatic logic tbl_a(input logic [3:0] idx);
    return (idx >= 4'd8) ? idx[0] : idx[1];
  endfunction

  function automatic logic tbl_b(input logic [3:0] idx);
    return (idx >= 4'd8) ? 1'b0 : idx[0];
  endfunction

  function automatic logic tbl_exp(input logic [3:0] idx);
    logic ta, tb;
    ta = tbl_a(idx);
    tb = tbl_b(idx);
    if (idx < 4'd4)      return ta & tb;
    else if (idx < 4'd8) return ta | tb;
    else                 return ~ta;
  endfunction

  function automatic logic sel_in(input logic [3:0] idx, input logic va,
                                  input logic vo, input logic vn);
    if (idx < 4'd4)      return va;
    else if (idx < 4'd8) return vo;
    else                 return vn;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;

    unique case (state_q)
      IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          fv_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        a_d     = tbl_a(idx_q);
        b_d     = tbl_b(idx_q);
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      SAMPLE: begin
        // Only place the gate outputs are looked at.
        if (sel_in(idx_q, and_in, or_in, not_in) != tbl_exp(idx_q)) begin
          fv_d  = fv_q | (10'd1 << idx_q);
          err_d = err_q + 4'd1;  // at most 10 checks, cannot overflow 4 bits
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        // err_q already includes the final SAMPLE update here.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 4'd0);
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

  localparam int S        = 2;
  localparam int CHK_LEN  = S + 2;
  localparam int DONE_CYC = 10 * CHK_LEN + 1;  // 41

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, and_in, or_in, not_in;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [9:0] fail_vec;

  // Behaviour of each simulated gate: 0 ideal, 1 stuck-0, 2 stuck-1, 3 inverted.
  logic [1:0] m_and = 2'd0, m_or = 2'd0, m_not = 2'd0;

  int errors = 0;
  int checks = 0;

  // Reference check table: gate (0 AND, 1 OR, 2 NOT), a, b, expected.
  int   t_gate [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
  logic t_a    [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1};
  logic t_b    [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
  logic t_exp  [10] = '{0, 0, 0, 1, 0, 1, 1, 1, 1, 0};

  typedef struct {
    logic [1:0] ma, mo, mn;
    logic [9:0] fv;
    logic [3:0] err;
    logic       pass;
    bit         restart;
  } vec_t;

  vec_t vecs [7];

  gate_sweep_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .and_in    (and_in),
    .or_in     (or_in),
    .not_in    (not_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  function automatic logic apply_mode(input logic [1:0] m, input logic v);
    case (m)
      2'd0:    return v;
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return ~v;
    endcase
  endfunction

  assign and_in = apply_mode(m_and, a & b);
  assign or_in  = apply_mode(m_or,  a | b);
  assign not_in = apply_mode(m_not, ~a);

  // A check fails exactly when the faulty gate's output differs from the table.
  function automatic logic [9:0] model_fv(input logic [1:0] ma, input logic [1:0] mo,
                                          input logic [1:0] mn);
    logic [9:0] fv;
    logic [1:0] m;
    fv = '0;
    for (int k = 0; k < 10; k++) begin
      m = (t_gate[k] == 0) ? ma : (t_gate[k] == 1) ? mo : mn;
      if (apply_mode(m, t_exp[k]) != t_exp[k]) fv[k] = 1'b1;
    end
    return fv;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Call at #1 after a rising edge. Starts a sweep and follows it cycle by cycle.
  task automatic run_sweep(input logic [9:0] efv, input logic [3:0] eerr,
                           input logic epass, input bit restart, input string tag);
    int c, done_cyc, ndone, busy_bad, ab_bad, k;
    done_cyc = -1; ndone = 0; busy_bad = 0; ab_bad = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    chk({tag, " busy_on_accept"}, busy, 1);
    while (c < DONE_CYC + 3) begin
      @(posedge clk); #1;
      c++;
      start = (restart && (c == 5 || c == 30)) ? 1'b1 : 1'b0;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c < DONE_CYC && !busy) busy_bad++;
      if (c >= DONE_CYC && busy) busy_bad++;
      // a/b as seen by the gate at each SAMPLE edge
      if (((c + 1) % CHK_LEN) == 0 && c < DONE_CYC) begin
        k = (c + 1) / CHK_LEN - 1;
        if (a !== t_a[k] || b !== t_b[k]) ab_bad++;
      end
      if (c >= DONE_CYC && (a !== 1'b0 || b !== 1'b0)) ab_bad++;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, done_cyc, DONE_CYC);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " busy_profile"}, busy_bad, 0);
    chk({tag, " ab_sequence"}, ab_bad, 0);
    chk({tag, " fail_vec"}, fail_vec, efv);
    chk({tag, " err_count"}, err_count, eerr);
    chk({tag, " pass"}, pass, epass);
  endtask

  initial begin
    logic [9:0] fv;
    int nd;

    vecs[0] = '{2'd0, 2'd0, 2'd0, 10'b0000000000, 4'd0, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 2'd0, 2'd0, 10'b0000001000, 4'd1, 1'b0, 1'b0};
    vecs[2] = '{2'd0, 2'd0, 2'd1, 10'b0100000000, 4'd1, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 2'd2, 2'd0, 10'b0000010000, 4'd1, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 2'd0, 2'd0, 10'b0000001111, 4'd4, 1'b0, 1'b0};
    vecs[5] = '{2'd2, 2'd2, 2'd2, 10'b1000010111, 4'd5, 1'b0, 1'b0};
    vecs[6] = '{2'd0, 2'd0, 2'd0, 10'b0000000000, 4'd0, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {a, b, busy, done, pass, err_count, fail_vec}, 0);
    rst_n = 1'b1;

    // Accepted on the first edge after reset release
    for (int i = 0; i < 7; i++) begin
      m_and = vecs[i].ma; m_or = vecs[i].mo; m_not = vecs[i].mn;
      run_sweep(vecs[i].fv, vecs[i].err, vecs[i].pass, vecs[i].restart,
                $sformatf("vec%0d", i));
    end

    // Results held while idle
    m_and = 2'd1;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_idle", {done, busy, pass, err_count, fail_vec}, {1'b0, 1'b0, 1'b1, 14'd0});

    // Reset during check 5 aborts with no done pulse
    m_and = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5 * CHK_LEN + 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midsweep_reset_outputs", {a, b, busy, done, pass, err_count, fail_vec}, 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midsweep_reset_no_done", nd, 0);
    rst_n = 1'b1;
    run_sweep(10'd0, 4'd0, 1'b1, 1'b0, "post_reset");

    // Randomised gate faults against the table model
    for (int r = 0; r < 8; r++) begin
      m_and = 2'($urandom_range(0, 3));
      m_or  = 2'($urandom_range(0, 3));
      m_not = 2'($urandom_range(0, 3));
      fv = model_fv(m_and, m_or, m_not);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_sweep(fv, 4'($countones(fv)), (fv == 10'd0), ($urandom_range(0, 1) == 1),
                $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
